// File: rtl/div_clk_scheduler.sv
// Glitch-free run-time selector between divider taps; clk_out is a gated, registered copy of the chosen tap.
// Optional feature macro: DIVSEL_TIMEOUT_EN adds a per-wait-state watchdog for stuck-high taps.
module div_clk_scheduler #(
    parameter int unsigned NUM_DIV     = 5,
    parameter int unsigned SEL_W       = 3,
    parameter int unsigned DEFAULT_SEL = 0,
    parameter int unsigned GAP_CYC     = 2
`ifdef DIVSEL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 200
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_DIV-1:0] div_in,
    input  logic               enable,
    input  logic               sel_req_valid,
    input  logic [SEL_W-1:0]   sel_req_idx,
    output logic               sel_req_ready,
    output logic               clk_out,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               switching,
    output logic               sel_done,
    output logic               sel_err,
    output logic               sel_timeout
);

    localparam int unsigned TAP_W = 1 << SEL_W;
    localparam int unsigned GAP_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OLD = 2'd1,
        GAP      = 2'd2,
        WAIT_NEW = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
    logic [SEL_W-1:0]   tgt_q, tgt_d;
    logic               gate_q, gate_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               sw_q, sw_d;
    logic               clk_out_q;

    // Zero-extend so any SEL_W-wide index is in range.
    logic [TAP_W-1:0]   taps;
    logic               cur_tap;
    logic               req_fire;
    logic               idx_bad;
    logic               wd_hit;
    logic               proceed;

    assign taps     = TAP_W'(div_in);
    assign cur_tap  = taps[cur_sel_q];
    assign req_fire = sel_req_valid & ready_q;
    assign idx_bad  = 32'(sel_req_idx) >= NUM_DIV;
    assign proceed  = ~cur_tap | wd_hit;

`ifdef DIVSEL_TIMEOUT_EN
    logic [7:0] wd_q, wd_d;
    logic       to_q, to_d;
    logic       in_wait;

    assign in_wait = (state_q == WAIT_OLD) || (state_q == WAIT_NEW);
    assign wd_hit  = in_wait && (wd_q >= 8'(TIMEOUT_CYC - 1));

    // Watchdog restarts on every entry to a wait state and saturates.
    always_comb begin
        wd_d = wd_q;
        to_d = 1'b0;
        if (wd_hit && cur_tap) begin
            to_d = 1'b1;
        end
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (in_wait && (wd_q != 8'hFF)) begin
            wd_d = wd_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign sel_timeout = to_q;
`else
    assign wd_hit      = 1'b0;
    assign sel_timeout = 1'b0;
`endif

    // Next-state and pulse logic.
    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        tgt_d     = tgt_q;
        gate_d    = gate_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_fire) begin
                    if (idx_bad) begin
                        err_d = 1'b1;
                    end else if (sel_req_idx == cur_sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        tgt_d   = sel_req_idx;
                        state_d = WAIT_OLD;
                    end
                end
            end
            WAIT_OLD: begin
                if (proceed) begin
                    gate_d    = 1'b0;
                    cur_sel_d = tgt_q;
                    gap_cnt_d = GAP_W'(GAP_CYC - 1);
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = WAIT_NEW;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            WAIT_NEW: begin
                if (proceed) begin
                    gate_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        sw_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cur_sel_q <= SEL_W'(DEFAULT_SEL);
            tgt_q     <= SEL_W'(DEFAULT_SEL);
            gate_q    <= 1'b1;
            gap_cnt_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
            sw_q      <= 1'b0;
            clk_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            tgt_q     <= tgt_d;
            gate_q    <= gate_d;
            gap_cnt_q <= gap_cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            sw_q      <= sw_d;
            clk_out_q <= gate_q & enable & cur_tap;
        end
    end

    assign sel_req_ready = ready_q;
    assign clk_out       = clk_out_q;
    assign cur_sel       = cur_sel_q;
    assign switching     = sw_q;
    assign sel_done      = done_q;
    assign sel_err       = err_q;

endmodule

// File: tb/tb_div_clk_scheduler.sv
// Scoreboard bench for div_clk_scheduler: divider taps modelled arithmetically, expected switch
// completions derived from tap phases and queued for a free-running monitor.
module tb_div_clk_scheduler;

    localparam int SEL_W = 3;
    localparam int NDIV  = 5;
    localparam int GAP   = 2;
    localparam int MAXC  = 16384;

    logic             clk;
    logic             reset;
    logic [NDIV-1:0]  div_in;
    logic             enable;
    logic             sel_req_valid;
    logic [SEL_W-1:0] sel_req_idx;
    logic             sel_req_ready;
    logic             clk_out;
    logic [SEL_W-1:0] cur_sel;
    logic             switching;
    logic             sel_done;
    logic             sel_err;
    logic             sel_timeout;

    div_clk_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .div_in        (div_in),
        .enable        (enable),
        .sel_req_valid (sel_req_valid),
        .sel_req_idx   (sel_req_idx),
        .sel_req_ready (sel_req_ready),
        .clk_out       (clk_out),
        .cur_sel       (cur_sel),
        .switching     (switching),
        .sel_done      (sel_done),
        .sel_err       (sel_err),
        .sel_timeout   (sel_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int cyc;
        bit is_err;
    } exp_t;

    exp_t exp_q[$];
    int   sel_at [MAXC];
    bit   low_at [MAXC];
    bit   sw_at  [MAXC];
    bit   en_at  [MAXC];
    bit   rst_at [MAXC];

    int n_checks = 0;
    int n_fail   = 0;
    int cur_k    = 0;
    int gap_start = 0;
    bit xfer;

    // Divider tap i during cycle c: high for the first half of each period.
    function automatic bit tap(input int i, input int c);
        int n;
        case (i)
            0: n = 4;
            1: n = 8;
            2: n = 9;
            3: n = 12;
            default: n = 80;
        endcase
        return (c % n) < (n / 2);
    endfunction

    function automatic logic [NDIV-1:0] taps_vec(input int c);
        logic [NDIV-1:0] v;
        for (int i = 0; i < NDIV; i++) v[i] = tap(i, c);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, edge_cnt, act, exp);
        end
    endtask

    // Predict the outcome of a request accepted in cycle k.
    task automatic model_transfer(input int k, input int idx);
        int old;
        int j;
        int m;
        old = sel_at[k];
        if (idx >= NDIV) begin
            exp_q.push_back('{cyc: k + 1, is_err: 1'b1});
        end else if (idx == old) begin
            exp_q.push_back('{cyc: k + 1, is_err: 1'b0});
        end else begin
            j = k + 1;
            while (tap(old, j)) j++;
            m = j + GAP + 1;
            while (tap(idx, m)) m++;
            for (int c = k + 1; c <= m; c++) sw_at[c] = 1'b1;
            for (int c = j + 1; c <= m + 1; c++) low_at[c] = 1'b1;
            for (int c = j + 1; c < MAXC; c++) sel_at[c] = idx;
            gap_start = j + 1;
            exp_q.push_back('{cyc: m + 1, is_err: 1'b0});
        end
    endtask

    task automatic drive_cycle(input bit v, input int idx, input bit en, input bit rs);
        int k;
        @(negedge clk);
        k = edge_cnt;
        cur_k = k;
        div_in        = taps_vec(k);
        enable        = en;
        reset         = rs;
        sel_req_valid = v;
        sel_req_idx   = SEL_W'(idx);
        en_at[k]  = en;
        rst_at[k] = rs;
        xfer = 1'b0;
        if (rs && !rst_at[k-1]) begin
            #1;
            chk("async_rst_cur_sel", int'(cur_sel), 0);
            chk("async_rst_clk_out", int'(clk_out), 0);
            chk("async_rst_switching", int'(switching), 0);
            chk("async_rst_ready", int'(sel_req_ready), 1);
            exp_q.delete();
            for (int c = k + 1; c < MAXC; c++) begin
                sel_at[c] = 0;
                low_at[c] = 1'b0;
                sw_at[c]  = 1'b0;
            end
        end else if (v && !rs && !sw_at[k]) begin
            xfer = 1'b1;
            model_transfer(k, idx);
        end
    endtask

    task automatic request(input int idx, input bit noisy);
        bit en;
        for (int t = 0; t < 500; t++) begin
            en = noisy ? ($urandom_range(0, 7) != 0) : 1'b1;
            if (sw_at[cur_k + 1])
                drive_cycle(noisy && ($urandom_range(0, 2) == 0), $urandom_range(0, 7), en, 1'b0);
            else
                drive_cycle(1'b1, idx, en, 1'b0);
            if (xfer) break;
        end
        if (!xfer) begin
            n_checks++;
            n_fail++;
            $display("FAIL request_accept cycle %0d: got no transfer expected transfer idx %0d", edge_cnt, idx);
        end
    endtask

    // Monitor: per-cycle output checks plus scoreboard pops on pulses.
    initial begin
        bit exp_clk;
        bit exp_done;
        bit exp_err;
        int c;
        forever begin
            @(posedge clk);
            #1;
            c = edge_cnt;
            if (c >= 1 && c < MAXC) begin
                if (rst_at[c-1]) begin
                    chk("rst_clk_out", int'(clk_out), 0);
                    chk("rst_cur_sel", int'(cur_sel), 0);
                    chk("rst_ready", int'(sel_req_ready), 1);
                    chk("rst_switching", int'(switching), 0);
                    chk("rst_done", int'(sel_done), 0);
                    chk("rst_err", int'(sel_err), 0);
                    chk("rst_timeout", int'(sel_timeout), 0);
                end else begin
                    exp_clk = low_at[c] ? 1'b0 : (en_at[c-1] && tap(sel_at[c-1], c - 1));
                    chk("clk_out", int'(clk_out), int'(exp_clk));
                    chk("cur_sel", int'(cur_sel), sel_at[c]);
                    chk("switching", int'(switching), int'(sw_at[c]));
                    chk("ready", int'(sel_req_ready), int'(!sw_at[c]));
                    chk("timeout", int'(sel_timeout), 0);
                    while (exp_q.size() > 0 && exp_q[0].cyc < c) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL stale_pulse cycle %0d: got none expected pulse at %0d", c, exp_q[0].cyc);
                        void'(exp_q.pop_front());
                    end
                    exp_done = (exp_q.size() > 0) && (exp_q[0].cyc == c) && !exp_q[0].is_err;
                    exp_err  = (exp_q.size() > 0) && (exp_q[0].cyc == c) && exp_q[0].is_err;
                    chk("sel_done", int'(sel_done), int'(exp_done));
                    chk("sel_err", int'(sel_err), int'(exp_err));
                    if (exp_done || exp_err) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        enable        = 1'b1;
        sel_req_valid = 1'b0;
        sel_req_idx   = '0;
        div_in        = taps_vec(0);
        rst_at[0]     = 1'b1;
        en_at[0]      = 1'b1;

        repeat (3) drive_cycle(1'b0, 0, 1'b1, 1'b1);
        repeat (20) drive_cycle(1'b0, 0, 1'b1, 1'b0);

        // Directed: switch to div80, bad index, same index.
        request(4, 1'b0);
        repeat (100) drive_cycle(1'b0, 0, 1'b1, 1'b0);
        request(5, 1'b0);
        repeat (4) drive_cycle(1'b0, 0, 1'b1, 1'b0);
        request(4, 1'b0);
        repeat (4) drive_cycle(1'b0, 0, 1'b1, 1'b0);

        // Directed: reset while holding clk_out low in the gap.
        request(1, 1'b0);
        while (cur_k + 1 < gap_start) drive_cycle(1'b0, 0, 1'b1, 1'b0);
        drive_cycle(1'b0, 0, 1'b1, 1'b1);
        drive_cycle(1'b0, 0, 1'b1, 1'b1);
        repeat (10) drive_cycle(1'b0, 0, 1'b1, 1'b0);

        // Random requests with enable toggling and ignored busy-time requests.
        for (int r = 0; r < 40 && cur_k < MAXC - 600; r++) begin
            repeat ($urandom_range(0, 6)) drive_cycle(1'b0, 0, ($urandom_range(0, 7) != 0), 1'b0);
            request($urandom_range(0, 7), 1'b1);
        end

        repeat (150) drive_cycle(1'b0, 0, 1'b1, 1'b0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
